// File: rtl/os_pkg.sv
// rtl/os_pkg.sv - shared defaults, state encoding and helpers for the output-stationary drain controller
//
// Contents:
//   PSUM_BW, COL, ROW, ADDR_BW : default array geometry and output SRAM address width
//   os_state_t                 : drain FSM state encoding
//   idx_width()                : width of a word index able to address n entries (never 0)
package os_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int ROW     = 8;
    localparam int ADDR_BW = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } os_state_t;

    // A 1x1 array still needs a 1-bit index so the counter never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/os_psum_buf.sv
// rtl/os_psum_buf.sv - snapshot register of all PE partial sums with an element-select read port
//
// Ports:
//   clk      : rising-edge clock
//   load     : capture the whole of data_in into the snapshot at this edge
//   data_in  : flattened PE outputs, element k at [psum_bw*k +: psum_bw]
//   index    : element to present on psum_out
//   psum_out : snapshot element selected by index (combinational)
//
// The snapshot has no reset: its contents are only observed after a load, and the
// controller only ever presents indices in 0..depth-1.
module os_psum_buf #(
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int idx_bw  = 6
) (
    input  logic                     clk,
    input  logic                     load,
    input  logic [psum_bw*depth-1:0] data_in,
    input  logic [idx_bw-1:0]        index,
    output logic [psum_bw-1:0]       psum_out
);

    logic [psum_bw-1:0] snap_q [depth];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < depth; i++) begin
                snap_q[i] <= data_in[psum_bw*i +: psum_bw];
            end
        end
    end

    always_comb begin
        psum_out = snap_q[index];
    end

endmodule

// File: rtl/os_drain_ctrl.sv
// rtl/os_drain_ctrl.sv - drains an output-stationary PE array into the output SRAM one word per transfer
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-high; returns to IDLE with all outputs low
//   start        : begin a drain (only honoured in IDLE)
//   relu_en      : clamp negative psums to zero for this drain (sampled with start)
//   base_addr    : first SRAM write address for this drain (sampled with start)
//   os_out_array : flattened PE outputs, element k = r*col+c at [psum_bw*k +: psum_bw]
//   acc_clr      : one-cycle pulse telling the PEs to clear their accumulators
//   out_valid    : out_data/out_addr carry a word for the SRAM
//   out_ready    : SRAM accepts the word this cycle
//   out_data     : drained psum (signed), zero when out_valid is low
//   out_addr     : write address, base_addr + k wrapping at 2^addr_bw, zero when out_valid is low
//   busy         : high while capturing or draining
//   done         : one-cycle pulse after the final word has been accepted
//
// Sequence: IDLE -start-> CAPTURE (1 cycle) -> DRAIN (row*col transfers) -> DONE (1 cycle) -> IDLE.
module os_drain_ctrl
    import os_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int row     = ROW,
    parameter int addr_bw = ADDR_BW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic [addr_bw-1:0]         base_addr,
    input  logic [psum_bw*col*row-1:0] os_out_array,
    output logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [psum_bw-1:0]         out_data,
    output logic [addr_bw-1:0]         out_addr,
    output logic                       busy,
    output logic                       done
);

    localparam int n_words = row * col;
    localparam int idx_bw  = idx_width(n_words);
    localparam logic [idx_bw-1:0] last_idx = idx_bw'(n_words - 1);

    os_state_t          state_q;
    os_state_t          state_d;
    logic [idx_bw-1:0]  k_q;
    logic [addr_bw-1:0] base_q;
    logic               relu_q;

    logic               xfer;
    logic               last_word;
    logic [psum_bw-1:0] buf_psum;
    logic [psum_bw-1:0] relu_psum;
    logic [addr_bw-1:0] word_addr;

    assign xfer      = (state_q == ST_DRAIN) && out_ready;
    assign last_word = (k_q == last_idx);

    // Snapshot is taken at the end of the CAPTURE cycle, the same edge at which the
    // PEs act on acc_clr, so no accumulated value is lost or counted twice.
    os_psum_buf #(
        .psum_bw (psum_bw),
        .depth   (n_words),
        .idx_bw  (idx_bw)
    ) u_psum_buf (
        .clk      (clk),
        .load     (state_q == ST_CAPTURE),
        .data_in  (os_out_array),
        .index    (k_q),
        .psum_out (buf_psum)
    );

    // ReLU on the sign bit only; the word stays two's complement otherwise.
    assign relu_psum = (relu_q && buf_psum[psum_bw-1]) ? '0 : buf_psum;

    // Address adder wraps naturally at 2^addr_bw.
    assign word_addr = base_q + addr_bw'(k_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DRAIN;
            ST_DRAIN:   if (xfer && last_word) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Per-drain context and word counter. k only moves on an accepted transfer, which
    // is what keeps out_data/out_addr stable while the sink stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q    <= '0;
            base_q <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        relu_q <= relu_en;
                    end
                end
                ST_CAPTURE: k_q <= '0;
                ST_DRAIN: begin
                    if (xfer) begin
                        k_q <= k_q + idx_bw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state register so they are all low in IDLE,
    // which is also where reset leaves the block.
    always_comb begin
        acc_clr   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_addr  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_CAPTURE: begin
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = relu_psum;
                out_addr  = word_addr;
                busy      = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_os_drain_ctrl.sv
// tb/tb_os_drain_ctrl.sv - scoreboard bench for os_drain_ctrl
module tb_os_drain_ctrl;
    import os_pkg::*;

    localparam int PW = 16;
    localparam int AW = 11;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          relu_en;
    logic [AW-1:0] base_addr;
    logic [PW*N-1:0] os_out_array;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0]    elem [N];
    logic [PW+AW-1:0] exp_q [$];

    always #5 clk = ~clk;

    os_drain_ctrl #(
        .psum_bw (PW),
        .col     (8),
        .row     (8),
        .addr_bw (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .relu_en      (relu_en),
        .base_addr    (base_addr),
        .os_out_array (os_out_array),
        .acc_clr      (acc_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_array();
        for (int i = 0; i < N; i++) os_out_array[PW*i +: PW] = elem[i];
    endtask

    // mode 0: out_ready always high; mode 1: out_ready 0,1,0,1... per DRAIN cycle.
    // disturb: random start pulses and random os_out_array during DRAIN.
    task automatic run_drain(input logic [AW-1:0] base, input logic relu, input int mode,
                             input bit disturb, input int exp_done, input string tag);
        int               cyc;
        int               didx;
        bit               got_done;
        logic             pv;
        logic             pr;
        logic [PW-1:0]    pd;
        logic [AW-1:0]    pa;
        logic [PW-1:0]    ed;
        logic [AW-1:0]    ea;
        logic [PW+AW-1:0] e;

        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            ed = (relu && elem[i][PW-1]) ? '0 : elem[i];
            ea = base + AW'(i);
            exp_q.push_back({ed, ea});
        end

        load_array();
        base_addr = base;
        relu_en   = relu;
        start     = 1'b1;
        out_ready = (mode == 0);
        tick();
        // cycle 1: CAPTURE. Live base/relu are flipped to prove they were latched.
        start     = 1'b0;
        base_addr = ~base;
        relu_en   = ~relu;
        checks++;
        if (acc_clr !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s capture: acc_clr=%b busy=%b out_valid=%b, want 1 1 0", tag, acc_clr, busy, out_valid);
        end
        tick();
        cyc = 2; didx = 0; pv = 1'b0; pr = 1'b0; pd = '0; pa = '0; got_done = 1'b0;
        while (cyc < exp_done + 20) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                for (int i = 0; i < N; i++) os_out_array[PW*i +: PW] = PW'($urandom);
            end
            out_ready = (mode == 0) ? 1'b1 : ((didx % 2) == 1);
            checks++;
            if (acc_clr !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s drain_ctl cyc=%0d: acc_clr=%b busy=%b out_valid=%b, want 0 1 1", tag, cyc, acc_clr, busy, out_valid);
            end
            if (out_valid === 1'b1) begin
                if (pv && !pr) begin
                    checks++;
                    if (out_data !== pd || out_addr !== pa) begin
                        errors++;
                        $display("FAIL %s stall_stable cyc=%0d: data=%h addr=%h, want %h %h", tag, cyc, out_data, out_addr, pd, pa);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_word cyc=%0d: data=%h addr=%h, want none", tag, cyc, out_data, out_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_data, out_addr} !== e) begin
                            errors++;
                            $display("FAIL %s word cyc=%0d: data=%h addr=%h, want %h %h", tag, cyc, out_data, out_addr, e[PW+AW-1:AW], e[AW-1:0]);
                        end
                    end
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr;
            didx++;
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (!got_done || cyc != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got=%0b at %0d, want 1 at %0d", tag, got_done, cyc, exp_done);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 || acc_clr !== 1'b0) begin
            errors++;
            $display("FAIL %s done_outputs: busy=%b valid=%b data=%h addr=%h acc_clr=%b, want all 0", tag, busy, out_valid, out_data, out_addr, acc_clr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_words: left=%0d, want 0", tag, exp_q.size());
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b, want 0 0 0", tag, done, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; relu_en = 1'b0; base_addr = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) elem[i] = '0;
        load_array();
        tick();
        tick();
        checks++;
        if (acc_clr !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: acc_clr=%b valid=%b data=%h addr=%h busy=%b done=%b, want all 0", acc_clr, out_valid, out_data, out_addr, busy, done);
        end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || acc_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b acc_clr=%b, want 0 0", busy, acc_clr);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) elem[i] = PW'(i);
        run_drain(11'h100, 1'b0, 0, 1'b0, 66, "basic");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) elem[i] = PW'(16'h1000 + i * 7);
        run_drain(11'h040, 1'b0, 1, 1'b0, 130, "backpressure");
    endtask

    task automatic test_relu();
        logic [PW-1:0] pat [4];
        pat[0] = 16'h8000; pat[1] = 16'hFFFF; pat[2] = 16'h0000; pat[3] = 16'h7FFF;
        for (int i = 0; i < N; i++) elem[i] = pat[i % 4];
        run_drain(11'h000, 1'b1, 0, 1'b0, 66, "relu_on");
        run_drain(11'h000, 1'b0, 0, 1'b0, 66, "relu_off");
    endtask

    task automatic test_addr_wrap();
        for (int i = 0; i < N; i++) elem[i] = PW'(16'hA000 + i);
        run_drain(11'h7FC, 1'b0, 0, 1'b0, 66, "addr_wrap");
    endtask

    task automatic test_disturb();
        for (int i = 0; i < N; i++) elem[i] = PW'($urandom);
        run_drain(11'h255, 1'b1, 0, 1'b1, 66, "disturb");
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < N; i++) elem[i] = PW'(i * 3 + 1);
        load_array();
        base_addr = 11'h020; relu_en = 1'b0; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (10) tick();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 11'h02A || out_data !== elem[10]) begin
            errors++;
            $display("FAIL midrst_k10: valid=%b addr=%h data=%h, want 1 02a %h", out_valid, out_addr, out_data, elem[10]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (acc_clr !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: acc_clr=%b valid=%b data=%h addr=%h busy=%b done=%b, want all 0", acc_clr, out_valid, out_data, out_addr, busy, done);
        end
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (done !== 1'b0 || acc_clr !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet c=%0d: done=%b acc_clr=%b busy=%b valid=%b, want 0 0 0 0", c, done, acc_clr, busy, out_valid);
            end
            tick();
        end
        for (int i = 0; i < N; i++) elem[i] = PW'(16'hC000 - i);
        run_drain(11'h3F0, 1'b0, 0, 1'b0, 66, "after_reset");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; base_addr = '0; out_ready = 1'b0; os_out_array = '0;
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_relu();
        test_addr_wrap();
        test_disturb();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/os_drain_ctrl.md
OS_DRAIN_CTRL -- requirements
Module: os_drain_ctrl

Interface
REQ-001 Parameter psum_bw, 16, bits per partial sum.
REQ-002 Parameter col, 8, PE columns.
REQ-003 Parameter row, 8, PE rows.
REQ-004 Parameter addr_bw, 11, output SRAM address width.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 start  input  1  request to drain current array results.
REQ-008 relu_en  input  1  clamp negative psums to zero; sampled with start.
REQ-009 base_addr  input  addr_bw  first write address; sampled with start.
REQ-010 os_out_array  input  psum_bw*col*row  flattened PE outputs; element k = bits [psum_bw*k +: psum_bw], k = r*col+c.
REQ-011 acc_clr  output  1  one-cycle pulse clearing PE accumulators after snapshot.
REQ-012 out_valid  output  1  out_data/out_addr hold a word for the output SRAM.
REQ-013 out_ready  input  1  sink accepts the word this cycle.
REQ-014 out_data  output  psum_bw  drained psum, signed two's complement.
REQ-015 out_addr  output  addr_bw  write address for out_data.
REQ-016 busy  output  1  high in CAPTURE and DRAIN.
REQ-017 done  output  1  one-cycle pulse after final word accepted.

Function
REQ-018 The block SHALL implement states IDLE, CAPTURE, DRAIN, DONE with a word index k (width ceil(log2(row*col))).
REQ-019 IDLE: start=1 SHALL latch base_addr and relu_en and move to CAPTURE at that edge; otherwise stay.
REQ-020 CAPTURE (exactly one cycle): SHALL register all of os_out_array into an internal snapshot, assert acc_clr for this cycle only, clear k, then move to DRAIN.
REQ-021 DRAIN: out_valid=1; out_data = snapshot element k, replaced by 0 when relu_en latched and its MSB is 1; out_addr = (base_addr + k) mod 2^addr_bw.
REQ-022 A transfer occurs on out_valid & out_ready; k SHALL increment only on a transfer; out_data/out_addr SHALL stay stable while out_ready is low.
REQ-023 Transfer at k = row*col-1 SHALL move to DONE; out_valid low from the next cycle.
REQ-024 DONE (one cycle): done=1, busy=0, then IDLE.
REQ-025 start outside IDLE SHALL be ignored (not queued).
REQ-026 os_out_array changes after CAPTURE SHALL not affect drained data.
REQ-027 With out_ready held high, done SHALL assert exactly row*col+2 cycles after the start cycle (66 at defaults); throughput one word/cycle.
REQ-028 Outputs out_data/out_addr SHALL be 0 whenever out_valid is 0.

Reset
REQ-029 reset SHALL force IDLE, k=0, snapshot don't-care, and all outputs 0 at the next edge, overriding start.
REQ-030 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the drain with no done pulse and no further acc_clr; next start after reset SHALL work normally.

Structure
REQ-031 Package os_pkg SHALL hold default psum_bw, col, row, addr_bw and the state encoding constants.
REQ-032 Snapshot register plus element-k mux SHALL be one sub-module, os_psum_buf (load, index in, psum out); FSM, counter, address adder and ReLU stay in os_drain_ctrl.

Verification
REQ-033 Reset, element k = k, base_addr=0x100, ready=1, start -> acc_clr cycle 1, 64 words data=k addr=0x100+k in order, done at cycle 66, busy low after.
REQ-034 out_ready alternating 1,0 -> data/addr stable on low cycles, each k emitted once, done after 128 DRAIN cycles.
REQ-035 relu_en=1, elements 0x8000, 0xFFFF, 0x0000, 0x7FFF -> out 0, 0, 0, 0x7FFF; relu_en=0 -> values unchanged.
REQ-036 base_addr=0x7FC -> addresses 0x7FC..0x7FF then 0x000..0x03B.
REQ-037 start pulses during DRAIN and os_out_array rewritten after CAPTURE -> output sequence and done timing unchanged.
REQ-038 reset asserted at k=10 -> all outputs 0 next cycle, no done; fresh start then drains all 64 words correctly.
